// File: rtl/fifo_sc_fwft.sv
// Single-clock FIFO with a standard registered read or a first-word-fall-through output stage.
// Level, threshold flags and handshake pulses are all registered and consistent with each other.
module fifo_sc_fwft #(
  parameter int dta_width         = 8,
  parameter int addr_width        = 8,
  parameter int prog_empty_thresh = 1,
  parameter int prog_full_thresh  = 1,
  parameter int fwft              = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [dta_width-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  prog_full,
  output logic [dta_width-1:0]  dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  valid,
  output logic                  underflow,
  output logic                  prog_empty,
  output logic [addr_width:0]   level
);
  localparam int LW    = addr_width + 1;
  localparam int DEPTH = 1 << addr_width;
  localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);
  localparam logic [LW-1:0] PE_LV    = LW'(prog_empty_thresh);
  localparam logic [LW-1:0] PF_LV    = LW'(DEPTH - prog_full_thresh);
  localparam logic [addr_width-1:0] PTR_ONE = {{(addr_width-1){1'b0}}, 1'b1};

  logic [dta_width-1:0]  r_mem [DEPTH];
  logic [addr_width-1:0] r_wptr, r_rptr;
  logic [LW-1:0]         r_level;
  logic                  r_full, r_empty, r_valid, r_wr_ack, r_overflow;
  logic                  r_underflow, r_prog_full, r_prog_empty;
  logic [dta_width-1:0]  r_dout;

  logic          w_clr, w_wr, w_load, w_dec, w_valid_nxt, w_empty_nxt, w_under;
  logic [LW-1:0] w_level_nxt, w_mem_cnt;

  assign w_clr     = rst | flush;
  assign w_wr      = wr_en & ~r_full & ~w_clr;
  // In FWFT mode the level includes the output stage; this is what remains in RAM.
  assign w_mem_cnt = r_level - {{addr_width{1'b0}}, r_valid};

  always_comb begin
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_valid_nxt = 1'b0;
    w_under     = 1'b0;
    if (fwft != 0) begin
      w_dec       = rd_en & r_valid;
      w_load      = (~r_valid | w_dec) & (w_mem_cnt != '0);
      w_valid_nxt = w_load | (r_valid & ~w_dec);
      w_under     = rd_en & ~r_valid;
    end else begin
      w_load      = rd_en & ~r_empty;
      w_dec       = w_load;
      w_valid_nxt = w_load;
      w_under     = rd_en & r_empty;
    end
    w_level_nxt = r_level + {{addr_width{1'b0}}, w_wr} - {{addr_width{1'b0}}, w_dec};
    w_empty_nxt = (fwft != 0) ? ~w_valid_nxt : (w_level_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= din;
  end

  // dout survives a flush so downstream logic keeps the last delivered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (!flush && w_load) begin
      r_dout <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_valid      <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_prog_empty <= 1'b1;
      r_prog_full  <= (PF_LV == '0);
    end else begin
      if (w_wr)   r_wptr <= r_wptr + PTR_ONE;
      if (w_load) r_rptr <= r_rptr + PTR_ONE;
      r_level      <= w_level_nxt;
      r_full       <= (w_level_nxt == DEPTH_LV);
      r_empty      <= w_empty_nxt;
      r_valid      <= w_valid_nxt;
      r_wr_ack     <= w_wr;
      r_overflow   <= wr_en & r_full;
      r_underflow  <= w_under;
      r_prog_empty <= (w_level_nxt <= PE_LV);
      r_prog_full  <= (w_level_nxt >= PF_LV);
    end
  end

  assign full       = r_full;
  assign wr_ack     = r_wr_ack;
  assign overflow   = r_overflow;
  assign prog_full  = r_prog_full;
  assign dout       = r_dout;
  assign empty      = r_empty;
  assign valid      = r_valid;
  assign underflow  = r_underflow;
  assign prog_empty = r_prog_empty;
  assign level      = r_level;
endmodule

// File: tb/tb_fifo_sc_fwft.sv
// Four FIFO configurations share one stimulus stream; each is checked against a queue model.
module tb_fifo_sc_fwft;
  localparam int ND = 4;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [7:0] din;

  wire [ND-1:0] o_full, o_ack, o_ovf, o_pf, o_empty, o_valid, o_unf, o_pe;
  wire [7:0]    o_dout [ND];
  wire [3:0]    o_lvl  [ND];
  wire [2:0]    lv0, lv1;
  wire [3:0]    lv2, lv3;

  assign o_lvl[0] = {1'b0, lv0};
  assign o_lvl[1] = {1'b0, lv1};
  assign o_lvl[2] = lv2;
  assign o_lvl[3] = lv3;

  int cfg_d  [ND] = '{4, 4, 8, 8};
  bit cfg_f  [ND] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int cfg_pe [ND] = '{1, 1, 2, 2};
  int cfg_pf [ND] = '{1, 1, 2, 2};

  logic [7:0] mq [ND][$];
  bit         mv [ND];
  bit         m_vp [ND];
  bit         m_ack [ND];
  bit         m_ovf [ND];
  bit         m_unf [ND];
  logic [7:0] m_dout [ND];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_sc_fwft #(.dta_width(8), .addr_width(2), .prog_empty_thresh(1), .prog_full_thresh(1), .fwft(0)) u_s4 (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en), .full(o_full[0]), .wr_ack(o_ack[0]),
    .overflow(o_ovf[0]), .prog_full(o_pf[0]), .dout(o_dout[0]), .rd_en(rd_en), .empty(o_empty[0]),
    .valid(o_valid[0]), .underflow(o_unf[0]), .prog_empty(o_pe[0]), .level(lv0));
  fifo_sc_fwft #(.dta_width(8), .addr_width(2), .prog_empty_thresh(1), .prog_full_thresh(1), .fwft(1)) u_f4 (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en), .full(o_full[1]), .wr_ack(o_ack[1]),
    .overflow(o_ovf[1]), .prog_full(o_pf[1]), .dout(o_dout[1]), .rd_en(rd_en), .empty(o_empty[1]),
    .valid(o_valid[1]), .underflow(o_unf[1]), .prog_empty(o_pe[1]), .level(lv1));
  fifo_sc_fwft #(.dta_width(8), .addr_width(3), .prog_empty_thresh(2), .prog_full_thresh(2), .fwft(0)) u_s8 (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en), .full(o_full[2]), .wr_ack(o_ack[2]),
    .overflow(o_ovf[2]), .prog_full(o_pf[2]), .dout(o_dout[2]), .rd_en(rd_en), .empty(o_empty[2]),
    .valid(o_valid[2]), .underflow(o_unf[2]), .prog_empty(o_pe[2]), .level(lv2));
  fifo_sc_fwft #(.dta_width(8), .addr_width(3), .prog_empty_thresh(2), .prog_full_thresh(2), .fwft(1)) u_f8 (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en), .full(o_full[3]), .wr_ack(o_ack[3]),
    .overflow(o_ovf[3]), .prog_full(o_pf[3]), .dout(o_dout[3]), .rd_en(rd_en), .empty(o_empty[3]),
    .valid(o_valid[3]), .underflow(o_unf[3]), .prog_empty(o_pe[3]), .level(lv3));

  // Words held: stored queue plus the FWFT output stage when it holds a word.
  function automatic int mlevel(int d);
    return mq[d].size() + ((cfg_f[d] && mv[d]) ? 1 : 0);
  endfunction

  function automatic logic [19:0] exp_vec(int d);
    int   lv;
    logic e_full, e_empty, e_valid, e_pe, e_pf;
    lv      = mlevel(d);
    e_full  = (lv == cfg_d[d]);
    e_empty = cfg_f[d] ? !mv[d] : (lv == 0);
    e_valid = cfg_f[d] ? mv[d] : m_vp[d];
    e_pe    = (lv <= cfg_pe[d]);
    e_pf    = (lv >= cfg_d[d] - cfg_pf[d]);
    return {e_full, m_ack[d], m_ovf[d], e_pf, e_empty, e_valid, m_unf[d], e_pe, 4'(lv), m_dout[d]};
  endfunction

  function automatic logic [19:0] obs_vec(int d);
    return {o_full[d], o_ack[d], o_ovf[d], o_pf[d], o_empty[d], o_valid[d], o_unf[d], o_pe[d],
            o_lvl[d], o_dout[d]};
  endfunction

  task automatic model_edge(int d);
    int lv;
    bit w, r;
    lv = mlevel(d);
    m_ack[d] = 1'b0; m_ovf[d] = 1'b0; m_unf[d] = 1'b0; m_vp[d] = 1'b0;
    if (rst || flush) begin
      mq[d].delete();
      mv[d] = 1'b0;
      if (rst) m_dout[d] = 8'h00;
    end else begin
      w = wr_en && (lv < cfg_d[d]);
      m_ack[d] = w;
      m_ovf[d] = wr_en && !w;
      if (!cfg_f[d]) begin
        r = rd_en && (lv > 0);
        m_unf[d] = rd_en && !r;
        m_vp[d]  = r;
        if (r) m_dout[d] = mq[d].pop_front();
      end else begin
        m_unf[d] = rd_en && !mv[d];
        if (rd_en && mv[d]) mv[d] = 1'b0;
        if (!mv[d] && mq[d].size() > 0) begin
          m_dout[d] = mq[d].pop_front();
          mv[d] = 1'b1;
        end
      end
      if (w) mq[d].push_back(din);
    end
  endtask

  task automatic drive(bit r, bit f, bit we, bit re, logic [7:0] dv);
    rst = r; flush = f; wr_en = we; rd_en = re; din = dv;
  endtask

  task automatic cyc(bit r, bit f, bit we, bit re, logic [7:0] dv);
    drive(r, f, we, re, dv);
    @(posedge clk);
    for (int d = 0; d < ND; d++) model_edge(d);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 8'h00);
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (obs_vec(d) !== exp_vec(d)) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, (i == 0), 8'h00);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL reset_idle dut%0d cyc%0d: got %h expected %h", d, i, obs_vec(d), exp_vec(d));
        end
      end
      n_cmp++;
      if (o_unf[0] !== 1'(i == 0)) begin
        n_fail++;
        $display("FAIL reset_underflow cyc%0d: got %b expected %b", i, o_unf[0], (i == 0));
      end
      n_cmp++;
      if ({o_empty[0], o_lvl[0], o_dout[0]} !== {1'b1, 4'd0, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_empty cyc%0d: got %b/%0d/%h expected 1/0/00", i, o_empty[0], o_lvl[0], o_dout[0]);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] pat [4];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, (i < 4) ? pat[i] : 8'h55);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL fill dut%0d cyc%0d: got %h expected %h", d, i, obs_vec(d), exp_vec(d));
        end
      end
    end
    n_cmp++;
    if ({o_full[0], o_ovf[0], o_lvl[0]} !== {1'b1, 1'b1, 4'd4}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b ovf=%b level=%0d expected 1 1 4", o_full[0], o_ovf[0], o_lvl[0]);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 8'h00);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL drain dut%0d cyc%0d: got %h expected %h", d, i, obs_vec(d), exp_vec(d));
        end
      end
      if (i < 4) begin
        n_cmp++;
        if ({o_valid[0], o_dout[0]} !== {1'b1, pat[i]}) begin
          n_fail++;
          $display("FAIL drain_data rd%0d: got v=%b %h expected v=1 %h", i, o_valid[0], o_dout[0], pat[i]);
        end
      end
    end
    n_cmp++;
    if ({o_empty[0], o_valid[0], o_unf[0]} !== 3'b101) begin
      n_fail++;
      $display("FAIL drain_end: got empty/valid/underflow=%b%b%b expected 101", o_empty[0], o_valid[0], o_unf[0]);
    end
  endtask

  task automatic test_fwft();
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'hA5);
    n_cmp++;
    if (o_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_early: got valid=%b expected 0", o_valid[1]);
    end
    cyc(0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({o_valid[1], o_empty[1], o_dout[1]} !== {1'b1, 1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL fwft_latency: got v=%b e=%b %h expected v=1 e=0 a5", o_valid[1], o_empty[1], o_dout[1]);
    end
    cyc(0, 0, 0, 1, 8'h00);
    n_cmp++;
    if ({o_valid[1], o_empty[1]} !== 2'b01) begin
      n_fail++;
      $display("FAIL fwft_pop_last: got v=%b e=%b expected v=0 e=1", o_valid[1], o_empty[1]);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, (i < 4), 0, 8'(i));
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL fwft_load dut%0d cyc%0d: got %h expected %h", d, i, obs_vec(d), exp_vec(d));
        end
      end
    end
    n_cmp++;
    if ({o_valid[1], o_dout[1]} !== {1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL fwft_head: got v=%b %h expected v=1 01", o_valid[1], o_dout[1]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 8'h00);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL fwft_stream dut%0d cyc%0d: got %h expected %h", d, i, obs_vec(d), exp_vec(d));
        end
      end
      n_cmp++;
      if (i < 2 && {o_valid[1], o_dout[1]} !== {1'b1, 8'(i + 2)}) begin
        n_fail++;
        $display("FAIL fwft_stream_data pop%0d: got v=%b %h expected v=1 %h", i, o_valid[1], o_dout[1], 8'(i + 2));
      end else if (i >= 2 && {o_valid[1], o_unf[1]} !== {1'b0, 1'(i == 3)}) begin
        n_fail++;
        $display("FAIL fwft_stream_end pop%0d: got v=%b unf=%b expected v=0 unf=%b", i, o_valid[1], o_unf[1], (i == 3));
      end
    end
  endtask

  task automatic test_simul();
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 8'($urandom));
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if ({o_lvl[d], o_ack[d]} !== {4'd2, 1'b1} || obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL simul_level2 dut%0d cyc%0d: got %h expected %h (level 2, ack 1)", d, i, obs_vec(d), exp_vec(d));
        end
      end
    end
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 8'($urandom));
    cyc(0, 0, 1, 1, 8'($urandom));
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({o_ovf[d], o_ack[d], o_lvl[d]} !== {1'b1, 1'b0, 4'd3}) begin
        n_fail++;
        $display("FAIL simul_full dut%0d: got ovf=%b ack=%b level=%0d expected 1 0 3", d, o_ovf[d], o_ack[d], o_lvl[d]);
      end
    end
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 1, 8'h00);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL simul_drain dut%0d cyc%0d: got %h expected %h", d, i, obs_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_thresholds();
    int lv;
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) cyc(0, 0, 1, 0, 8'($urandom));
      lv = (i > 8) ? 8 : i;
      for (int d = 2; d < ND; d++) begin
        n_cmp++;
        if ({o_lvl[d], o_pe[d], o_pf[d]} !== {4'(lv), 1'(lv <= 2), 1'(lv >= 6)}) begin
          n_fail++;
          $display("FAIL thresh dut%0d level%0d: got lvl=%0d pe=%b pf=%b expected pe=%b pf=%b",
                   d, lv, o_lvl[d], o_pe[d], o_pf[d], (lv <= 2), (lv >= 6));
        end
      end
    end
  endtask

  task automatic test_flush();
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 8'hC0 + 8'(i));
    cyc(0, 0, 0, 1, 8'h00);
    n_cmp++;
    if ({o_lvl[2], o_dout[2]} !== {4'd5, 8'hC0}) begin
      n_fail++;
      $display("FAIL flush_pre: got level=%0d dout=%h expected 5 c0", o_lvl[2], o_dout[2]);
    end
    cyc(0, 1, 1, 1, 8'hEE);
    for (int d = 0; d < ND; d += 2) begin
      n_cmp++;
      if ({o_lvl[d], o_empty[d], o_ack[d], o_valid[d], o_dout[d]} !== {4'd0, 3'b100, 8'hC0}) begin
        n_fail++;
        $display("FAIL flush dut%0d: got lvl=%0d e=%b ack=%b v=%b dout=%h expected 0 1 0 0 c0",
                 d, o_lvl[d], o_empty[d], o_ack[d], o_valid[d], o_dout[d]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, (i < 3), (i >= 3), 8'hD1 + 8'(i));
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL flush_after dut%0d cyc%0d: got %h expected %h", d, i, obs_vec(d), exp_vec(d));
        end
      end
      n_cmp++;
      if (i >= 3 && {o_valid[2], o_dout[2]} !== {1'b1, 8'hD1 + 8'(i - 3)}) begin
        n_fail++;
        $display("FAIL flush_order rd%0d: got v=%b %h expected v=1 %h", i - 3, o_valid[2], o_dout[2], 8'hD1 + 8'(i - 3));
      end
    end
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 0, 8'h00);
    for (int c = 0; c < 4000; c++) begin
      int ph, pw, pr;
      ph = (c / 250) % 3;
      pw = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
      pr = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
      cyc(($urandom_range(499) == 0), ($urandom_range(79) == 0),
          ($urandom_range(99) < pw), ($urandom_range(99) < pr), 8'($urandom));
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 8'h00);
    test_reset();
    test_fill_drain();
    test_fwft();
    test_simul();
    test_thresholds();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
